// File: rtl/vga_scan_driver.sv
// VGA raster timing generator with registered colour/sync output stage.
// Pixel coordinates lead the physical outputs by one pixel period.
module vga_scan_driver #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [11:0]        color,
  output logic signed [31:0] pix_x,
  output logic signed [31:0] pix_y,
  output logic [3:0]         vga_r,
  output logic [3:0]         vga_g,
  output logic [3:0]         vga_b,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned T_MAX   =
    (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
  localparam int unsigned CW_RAW  = $clog2(T_MAX);
  localparam int unsigned CW      = (CW_RAW < 10) ? 10 : CW_RAW;
  localparam int unsigned DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_cnt;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          tick;
  logic          h_wrap;
  logic          v_wrap;
  logic          act;
  logic          hs_on;
  logic          vs_on;

  assign tick   = (div_cnt == DIV_LAST);
  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);
  assign act    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_on  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_on  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

  assign pix_x = {{(32-CW){1'b0}}, h_cnt};
  assign pix_y = {{(32-CW){1'b0}}, v_cnt};

  // Output stage samples the pre-increment counters on the tick,
  // so every physical output trails its coordinate by one pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt     <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      de          <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      div_cnt     <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
        if (h_wrap) begin
          v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
        end
        de                    <= act;
        {vga_r, vga_g, vga_b} <= act ? color : 12'h000;
        hsync                 <= hs_on ? SYNC_POL : ~SYNC_POL;
        vsync                 <= vs_on ? SYNC_POL : ~SYNC_POL;
        frame_start           <= h_wrap && v_wrap;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_driver.sv
// Scoreboard bench for vga_scan_driver on a shrunken raster.
// Expected outputs are queued per pixel and popped on each pixel tick.
module tb_vga_scan_driver;

  localparam int CD  = 4;
  localparam int HA  = 16;
  localparam int HFP = 2;
  localparam int HS  = 4;
  localparam int HBP = 3;
  localparam int VA  = 6;
  localparam int VFP = 2;
  localparam int VS  = 2;
  localparam int VBP = 3;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int FRAME = CD * HT * VT;

  typedef logic [14:0] out_t;
  localparam out_t RST_OUT = {1'b0, 12'h000, 1'b1, 1'b1};

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [11:0]        color = 12'h000;
  logic signed [31:0] pix_x;
  logic signed [31:0] pix_y;
  logic [3:0]         vga_r;
  logic [3:0]         vga_g;
  logic [3:0]         vga_b;
  logic               hsync;
  logic               vsync;
  logic               de;
  logic               frame_start;

  vga_scan_driver #(
    .CLK_DIV (CD),
    .H_ACTIVE(HA),
    .H_FP    (HFP),
    .H_SYNC  (HS),
    .H_BP    (HBP),
    .V_ACTIVE(VA),
    .V_FP    (VFP),
    .V_SYNC  (VS),
    .V_BP    (VBP),
    .SYNC_POL(1'b0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .color      (color),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int     n_vec = 0;
  int     n_bad = 0;
  out_t   sb[$];
  out_t   cur;
  int     k;
  longint cyc;
  longint last_fs;
  int     hs_low;

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)",
               tag, got, exp, k);
    end
  endtask

  function automatic out_t model(input int p, input logic [11:0] c);
    int   h;
    int   v;
    logic a;
    logic hs;
    logic vs;
    h  = p % HT;
    v  = (p / HT) % VT;
    a  = (h < HA) && (v < VA);
    hs = !((h >= HA + HFP) && (h < HA + HFP + HS));
    vs = !((v >= VA + VFP) && (v < VA + VFP + VS));
    return {a, (a ? c : 12'h000), hs, vs};
  endfunction

  task automatic check_rst_state(input string tag);
    check_eq({tag, "_x"}, pix_x, 0);
    check_eq({tag, "_y"}, pix_y, 0);
    check_eq({tag, "_out"},
             {de, vga_r, vga_g, vga_b, hsync, vsync}, RST_OUT);
    check_eq({tag, "_fs"}, frame_start, 0);
  endtask

  // One clk: starts and ends on a negedge.
  task automatic step();
    int         p;
    logic [11:0] c;
    out_t       exp;
    logic       fs_exp;
    p = k / CD;
    check_eq("pix_x", pix_x, p % HT);
    check_eq("pix_y", pix_y, (p / HT) % VT);
    if (k % CD == 0) begin
      c = 12'($urandom);
      if ($urandom_range(0, 3) == 0) c = 12'hfff;
      if (p == 0) c = 12'h0ff;
      color = c;
      sb.push_back(model(p, c));
    end
    @(posedge clk);
    #1;
    k++;
    cyc++;
    if (k % CD == 0) begin
      if (sb.size() == 0) check_eq("sb_underflow", 0, 1);
      else cur = sb.pop_front();
    end
    exp = (k < CD) ? RST_OUT : cur;
    check_eq("outs", {de, vga_r, vga_g, vga_b, hsync, vsync}, exp);
    fs_exp = (k % CD == 0) && ((k / CD) % (HT * VT) == 0);
    check_eq("frame_start", frame_start, fs_exp);
    if (frame_start) begin
      if (last_fs >= 0) check_eq("fs_period", 32'(cyc - last_fs), FRAME);
      last_fs = cyc;
    end
    if (k >= CD && k < CD * HT + CD && !hsync) hs_low++;
    if (k == CD * HT + CD - 1) check_eq("hs_width", hs_low, HS * CD);
    @(negedge clk);
  endtask

  initial begin
    k       = 0;
    cyc     = 0;
    last_fs = -1;
    hs_low  = 0;
    repeat (10) @(negedge clk);
    check_rst_state("rst");
    reset = 1'b1;
    repeat (2 * FRAME + CD * (HT * 4 + 10)) step();
    check_eq("pre_rst_x", pix_x, 10);
    check_eq("pre_rst_y", pix_y, 4);
    reset = 1'b0;
    #1;
    check_rst_state("mid_rst");
    sb.delete();
    last_fs = -1;
    hs_low  = 0;
    repeat (3) @(negedge clk);
    check_rst_state("mid_hold");
    reset = 1'b1;
    k = 0;
    repeat (FRAME + 8 * CD) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
